// File: rtl/dbus_mem_ctrl.sv
// dbus_mem_ctrl: MEM-stage data-bus sequencer.
//   Takes one load/store request at a time from the pipeline, rejects misaligned
//   accesses, drives a latched request onto dreq_* and stalls the pipeline until
//   the bus completes. The raw 64-bit read beat and the low address bits go to
//   writeback. Also keeps a saturating count of stalled cycles.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_*                       MEM-stage request (held stable while stall=1)
//   flush                       squash the current request
//   stall, misalign             pipeline hold / misaligned reject (combinational)
//   resp_valid/rdata/addr_low   completion pulse, raw read beat, latched addr[2:0]
//   dreq_*                      bus request (driven from latched registers only)
//   dresp_addr_ok/data_ok/data  bus handshake and read data
//   stall_cycles                saturating count of cycles with stall=1
module dbus_mem_ctrl #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [63:0]       req_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              misalign,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic [2:0]        resp_addr_low,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [63:0]       dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [63:0]       dresp_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [7:0]        strobe_q;
  logic [63:0]       data_q;
  logic [2:0]        addr_low_q;
  logic [63:0]       rdata_q;
  logic              squash_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              misaligned;
  logic              accept;
  logic [7:0]        strobe_base;
  logic [7:0]        strobe_new;
  logic [63:0]       data_new;

  // Size decode: byte mask before lane shift, and alignment check.
  always_comb begin
    strobe_base = 8'h00;
    misaligned  = 1'b0;
    case (req_size)
      3'd0: strobe_base = 8'h01;
      3'd1: begin
        strobe_base = 8'h03;
        misaligned  = req_addr[0];
      end
      3'd2: begin
        strobe_base = 8'h0F;
        misaligned  = |req_addr[1:0];
      end
      3'd3: begin
        strobe_base = 8'hFF;
        misaligned  = |req_addr[2:0];
      end
      default: ;
    endcase
  end

  assign strobe_new = req_write ? (strobe_base << req_addr[2:0]) : 8'h00;
  assign data_new   = req_wdata << {req_addr[2:0], 3'b000};

  assign accept   = (state_q == StIdle) && req_valid && !misaligned && !flush;
  assign misalign = (state_q == StIdle) && req_valid && misaligned;
  // Stall covers the accept cycle and the whole bus handshake; DONE releases it.
  assign stall    = accept || (state_q == StReq) || (state_q == StWait);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      data_q     <= '0;
      addr_low_q <= '0;
      rdata_q    <= '0;
      squash_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            strobe_q   <= strobe_new;
            data_q     <= data_new;
            addr_low_q <= req_addr[2:0];
            state_q    <= StReq;
          end
        end
        StReq: begin
          // The bus handshake is never abandoned; a flush only suppresses the response.
          if (flush) squash_q <= 1'b1;
          // data_ok without addr_ok counts as both.
          if (dresp_data_ok) begin
            rdata_q <= dresp_data;
            state_q <= StDone;
          end else if (dresp_addr_ok) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (flush) squash_q <= 1'b1;
          if (dresp_data_ok) begin
            rdata_q <= dresp_data;
            state_q <= StDone;
          end
        end
        StDone: begin
          squash_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid    = (state_q == StDone) && !squash_q;
  assign resp_rdata    = rdata_q;
  assign resp_addr_low = addr_low_q;
  assign dreq_valid    = (state_q == StReq);
  assign dreq_addr     = addr_q;
  assign dreq_size     = size_q;
  assign dreq_strobe   = strobe_q;
  assign dreq_data     = data_q;
  assign stall_cycles  = cnt_q;

endmodule

// File: tb/tb_dbus_mem_ctrl.sv
module tb_dbus_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, flush;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  logic        stall, misalign, resp_valid, dreq_valid;
  logic [63:0] resp_rdata, dreq_addr, dreq_data;
  logic [2:0]  resp_addr_low, dreq_size;
  logic [7:0]  dreq_strobe;
  logic [31:0] stall_cycles;

  logic        stall4, misalign4, resp_valid4, dreq_valid4;
  logic [63:0] resp_rdata4, dreq_addr4, dreq_data4;
  logic [2:0]  resp_addr_low4, dreq_size4;
  logic [7:0]  dreq_strobe4;
  logic [3:0]  stall_cycles4;

  dbus_mem_ctrl #(.ADDR_W(64), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .misalign(misalign), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_addr_low(resp_addr_low), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall_cycles(stall_cycles)
  );

  // Same stimulus, narrow counter to exercise saturation.
  dbus_mem_ctrl #(.ADDR_W(64), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .flush(flush),
    .stall(stall4), .misalign(misalign4), .resp_valid(resp_valid4), .resp_rdata(resp_rdata4),
    .resp_addr_low(resp_addr_low4), .dreq_valid(dreq_valid4), .dreq_addr(dreq_addr4),
    .dreq_size(dreq_size4), .dreq_strobe(dreq_strobe4), .dreq_data(dreq_data4),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall_cycles(stall_cycles4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic [2:0]  low;
  } resp_t;

  resp_t       resp_exp[$];
  resp_t       mon_e;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned m_stall  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written from the access semantics: an N-byte access is aligned
  // when addr is a multiple of N; it touches N consecutive byte lanes from addr%8.
  function automatic bit mis_m(input logic [63:0] a, input logic [2:0] s);
    int unsigned nbytes = 1 << s;
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [7:0] strobe_m(input logic [63:0] a, input logic [2:0] s);
    int unsigned nbytes = 1 << s;
    int unsigned mask = ((1 << nbytes) - 1) << (a % 8);
    return mask[7:0];
  endfunction

  function automatic logic [63:0] data_m(input logic [63:0] a, input logic [63:0] wd);
    return wd << (8 * (a % 8));
  endfunction

  // Response monitor: pops one expected entry per resp_valid pulse.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (resp_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=1 expected=0 t=%0t", $time);
      end else begin
        mon_e = resp_exp.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_addr_low", {61'd0, resp_addr_low}, {61'd0, mon_e.low});
      end
    end
  end

  // Called at posedge+1 with the DUT idle. ad: REQ cycles before addr_ok;
  // dd: cycles after the addr_ok cycle until data_ok; fl: busy cycle index to flush in (-1 none).
  task automatic do_access(input bit wr, input logic [63:0] addr, input logic [2:0] size,
                           input logic [63:0] wd, input int ad, input int dd, input int fl,
                           input logic [63:0] rd, input bit only_data);
    bit          mis;
    int          busy;
    logic [7:0]  exp_strobe;
    resp_t       e;
    mis = mis_m(addr, size);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wd;
    flush = 1'b0;
    @(negedge clk);
    chk("misalign", {63'd0, misalign}, {63'd0, mis});
    chk("stall_accept", {63'd0, stall}, {63'd0, !mis});
    if (mis) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("mis_no_dreq", {63'd0, dreq_valid}, 64'd0);
      chk("mis_no_stall_cnt", {32'd0, stall_cycles}, {32'd0, m_stall});
      @(posedge clk); #1;
      return;
    end
    m_stall++;
    exp_strobe = wr ? strobe_m(addr, size) : 8'h00;
    if (fl < 0) begin
      e.rdata = rd;
      e.low   = addr[2:0];
      resp_exp.push_back(e);
    end
    busy = ad + 1 + dd;
    for (int c = 0; c < busy; c++) begin
      @(posedge clk); #1;
      dresp_addr_ok = (c == ad) && !(only_data && dd == 0);
      dresp_data_ok = (c == ad + dd);
      dresp_data    = (c == ad + dd) ? rd : {$urandom, $urandom};
      flush         = (c == fl);
      @(negedge clk);
      m_stall++;
      chk("stall_busy", {63'd0, stall}, 64'd1);
      if (c <= ad) begin
        chk("dreq_valid_req", {63'd0, dreq_valid}, 64'd1);
        chk("dreq_addr", dreq_addr, addr);
        chk("dreq_size", {61'd0, dreq_size}, {61'd0, size});
        chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, exp_strobe});
        if (wr) chk("dreq_data", dreq_data, data_m(addr, wd));
      end else begin
        chk("dreq_valid_wait", {63'd0, dreq_valid}, 64'd0);
      end
    end
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("stall_done", {63'd0, stall}, 64'd0);
    chk("resp_valid_done", {63'd0, resp_valid}, {63'd0, fl < 0});
    chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
    @(posedge clk); #1;
  endtask

  task automatic rand_access();
    logic [2:0]  s;
    logic [63:0] a;
    int          ad, dd, fl;
    s = 3'($urandom_range(0, 3));
    a = {$urandom, $urandom};
    if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << s) - 64'd1);
    ad = $urandom_range(0, 3);
    dd = $urandom_range(0, 3);
    fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ad + dd) : -1;
    do_access(1'($urandom_range(0, 1)), a, s, {$urandom, $urandom}, ad, dd, fl,
              {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    #12;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rst_cnt", {32'd0, stall_cycles}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Byte store, immediate completion.
    do_access(1'b1, 64'h1003, 3'd0, 64'hAB, 0, 0, -1, 64'h0, 1'b0);
    // Word load, addr_ok after 2 extra REQ cycles, data 3 cycles later.
    do_access(1'b0, 64'h2004, 3'd2, 64'h0, 2, 3, -1, 64'h1122334455667788, 1'b0);
    // Misaligned doubleword load.
    do_access(1'b0, 64'h3004, 3'd3, 64'h0, 0, 0, -1, 64'h0, 1'b0);
    // Flush in WAIT, then an immediately following request.
    do_access(1'b0, 64'h4000, 3'd3, 64'h0, 0, 3, 1, 64'hDEADBEEF, 1'b0);
    do_access(1'b1, 64'h5002, 3'd1, 64'hCAFE, 1, 0, -1, 64'h55, 1'b1);

    // Flush in IDLE: request ignored.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h6000; req_size = 3'd2; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_dreq", {63'd0, dreq_valid}, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) rand_access();
    chk("cnt4_sat", {60'd0, stall_cycles4}, (m_stall > 15) ? 64'd15 : 64'(m_stall));

    // Reset in WAIT.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h7008; req_size = 3'd3;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("wait_before_rst", {63'd0, dreq_valid}, 64'd0);
    #2;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    m_stall = 0;
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("arst_dreq_addr", dreq_addr, 64'd0);
    chk("arst_cnt", {32'd0, stall_cycles}, 64'd0);
    chk("arst_cnt4", {60'd0, stall_cycles4}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    dresp_data_ok = 1'b1; dresp_data = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {63'd0, stall}, 64'd0);
    chk("post_rst_rdata", resp_rdata, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) rand_access();
    repeat (2) @(posedge clk);
    chk("resp_queue_empty", 64'(resp_exp.size()), 64'd0);
    chk("final_cnt4", {60'd0, stall_cycles4}, (m_stall > 15) ? 64'd15 : 64'(m_stall));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
